operand_fetch_ctrl: RTL and testbench

- Initiator-side controller for the integer architectural register file (2 read ports p0/p1, 1 write port p2).
- Accepts decoded instructions from decode and reads rs1/rs2 through p0/p1, then hands the operands to execute with a valid/ready handshake.
- Forwards writeback results to p2.
- Keeps a per-register busy scoreboard so no instruction reads or re-targets a register with a pending write.

---
 rtl/operand_fetch_ctrl_pkg.sv | 21 ++
 rtl/operand_fetch_ctrl_scoreboard.sv | 43 ++++
 rtl/operand_fetch_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_operand_fetch_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_ctrl_pkg.sv
// Shared definitions for the operand fetch controller: FSM encoding, size defaults
// and ABI register names.
package operand_fetch_ctrl_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int AW_DEF    = 5;
  localparam int TAG_W_DEF = 4;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_CAPT, S_HOLD} state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd1;
  localparam logic [4:0] REG_SP   = 5'd2;
  localparam logic [4:0] REG_GP   = 5'd3;
  localparam logic [4:0] REG_TP   = 5'd4;
  localparam logic [4:0] REG_T0   = 5'd5;
  localparam logic [4:0] REG_T1   = 5'd6;
  localparam logic [4:0] REG_T2   = 5'd7;
  localparam logic [4:0] REG_S0   = 5'd8;
  localparam logic [4:0] REG_S1   = 5'd9;
  localparam logic [4:0] REG_A0   = 5'd10;
endpackage

// File: rtl/operand_fetch_ctrl_scoreboard.sv
// Per-register pending-write tracker; x0 is never marked busy.
module reg_scoreboard
  import operand_fetch_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en_i,
  input  logic [AW-1:0] set_idx_i,
  input  logic          clr_en_i,
  input  logic [AW-1:0] clr_idx_i,
  input  logic          chk_use1_i,
  input  logic [AW-1:0] chk_idx1_i,
  input  logic          chk_use2_i,
  input  logic [AW-1:0] chk_idx2_i,
  input  logic          chk_wr_i,
  input  logic [AW-1:0] chk_rd_i,
  input  logic [AW-1:0] probe_idx_i,
  output logic          probe_busy_o,
  output logic          hazard_o
);
  localparam int NREG = 1 << AW;

  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    if (set_en_i) busy_d[set_idx_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign hazard_o = (chk_use1_i & busy_q[chk_idx1_i]) |
                    (chk_use2_i & busy_q[chk_idx2_i]) |
                    (chk_wr_i   & busy_q[chk_rd_i]);
  assign probe_busy_o = busy_q[probe_idx_i];
endmodule

// File: rtl/operand_fetch_ctrl.sv
// Issue-side register file controller: reads rs1/rs2 over p0/p1, hands operands to
// execute, forwards writebacks to p2 and tracks pending writes.
module operand_fetch_ctrl
  import operand_fetch_ctrl_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int AW    = AW_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iss_valid,
  output logic             iss_ready,
  input  logic [AW-1:0]    iss_rs1,
  input  logic [AW-1:0]    iss_rs2,
  input  logic [AW-1:0]    iss_rd,
  input  logic             iss_use_rs1,
  input  logic             iss_use_rs2,
  input  logic             iss_wr_rd,
  input  logic [TAG_W-1:0] iss_tag,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [XLEN-1:0]  op_rs1_val,
  output logic [XLEN-1:0]  op_rs2_val,
  output logic [AW-1:0]    op_rd,
  output logic             op_wr_rd,
  output logic [TAG_W-1:0] op_tag,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic [AW-1:0]    rf_addr_p0,
  output logic [AW-1:0]    rf_addr_p1,
  output logic             rf_re_p0,
  output logic             rf_re_p1,
  input  logic [XLEN-1:0]  rf_dout_p0,
  input  logic [XLEN-1:0]  rf_dout_p1,
  output logic [AW-1:0]    rf_addr_p2,
  output logic             rf_we_p2,
  output logic [XLEN-1:0]  rf_din_p2,
  output logic             err_wb_unexp
);
  state_e            state_q, state_d;
  logic [AW-1:0]     rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic              use1_q, use1_d, use2_q, use2_d, wr_q, wr_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              op_valid_q, op_valid_d;
  logic [XLEN-1:0]   v1_q, v1_d, v2_q, v2_d;
  logic              we_q, err_q;
  logic [AW-1:0]     waddr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              hazard, probe_busy, set_en, wb_take, wb_unexp;

  reg_scoreboard #(.AW(AW)) u_sb (
    .clk         (clk),
    .reset       (reset),
    .set_en_i    (set_en),
    .set_idx_i   (iss_rd),
    .clr_en_i    (we_q),
    .clr_idx_i   (waddr_q),
    .chk_use1_i  (iss_use_rs1),
    .chk_idx1_i  (iss_rs1),
    .chk_use2_i  (iss_use_rs2),
    .chk_idx2_i  (iss_rs2),
    .chk_wr_i    (iss_wr_rd),
    .chk_rd_i    (iss_rd),
    .probe_idx_i (wb_rd),
    .probe_busy_o(probe_busy),
    .hazard_o    (hazard)
  );

  always_comb begin
    state_d    = state_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    use1_d     = use1_q;
    use2_d     = use2_q;
    wr_d       = wr_q;
    tag_d      = tag_q;
    op_valid_d = op_valid_q;
    v1_d       = v1_q;
    v2_d       = v2_q;
    set_en     = 1'b0;
    iss_ready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        iss_ready = ~hazard;
        if (iss_valid && !hazard) begin
          rs1_d   = iss_rs1;
          rs2_d   = iss_rs2;
          rd_d    = iss_rd;
          use1_d  = iss_use_rs1;
          use2_d  = iss_use_rs2;
          wr_d    = iss_wr_rd;
          tag_d   = iss_tag;
          set_en  = iss_wr_rd;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_CAPT;
      S_CAPT: begin
        // x0 and unused operands read as zero whatever the array returns
        v1_d       = (use1_q && rs1_q != '0) ? rf_dout_p0 : '0;
        v2_d       = (use2_q && rs2_q != '0) ? rf_dout_p1 : '0;
        op_valid_d = 1'b1;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (op_ready) begin
          op_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      use1_q     <= 1'b0;
      use2_q     <= 1'b0;
      wr_q       <= 1'b0;
      tag_q      <= '0;
      op_valid_q <= 1'b0;
      v1_q       <= '0;
      v2_q       <= '0;
    end else begin
      state_q    <= state_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      use1_q     <= use1_d;
      use2_q     <= use2_d;
      wr_q       <= wr_d;
      tag_q      <= tag_d;
      op_valid_q <= op_valid_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
    end
  end

  // Writeback path runs independently of the issue FSM
  assign wb_take  = wb_valid && (wb_rd != '0);
  assign wb_unexp = wb_take && !probe_busy && !(we_q && waddr_q == wb_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q <= wb_take;
      if (wb_take) begin
        waddr_q <= wb_rd;
        wdata_q <= wb_data;
      end
      if (wb_unexp) err_q <= 1'b1;
    end
  end

  assign op_valid     = op_valid_q;
  assign op_rs1_val   = v1_q;
  assign op_rs2_val   = v2_q;
  assign op_rd        = rd_q;
  assign op_wr_rd     = wr_q;
  assign op_tag       = tag_q;
  assign rf_addr_p0   = rs1_q;
  assign rf_addr_p1   = rs2_q;
  assign rf_re_p0     = (state_q == S_READ) && use1_q;
  assign rf_re_p1     = (state_q == S_READ) && use2_q;
  assign rf_addr_p2   = waddr_q;
  assign rf_we_p2     = we_q;
  assign rf_din_p2    = wdata_q;
  assign err_wb_unexp = err_q;
endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Bench for operand_fetch_ctrl: behavioural register file, vector table and
// hand-written hazard/back-pressure/reset sequences with an expected-result queue.
module tb_operand_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_use_rs1, iss_use_rs2, iss_wr_rd;
  logic [3:0]  iss_tag;
  logic        op_valid, op_ready;
  logic [31:0] op_rs1_val, op_rs2_val;
  logic [4:0]  op_rd;
  logic        op_wr_rd;
  logic [3:0]  op_tag;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rf_addr_p0, rf_addr_p1, rf_addr_p2;
  logic        rf_re_p0, rf_re_p1, rf_we_p2;
  logic [31:0] rf_dout_p0, rf_dout_p1, rf_din_p2;
  logic        err_wb_unexp;

  int nerr = 0;
  int nchk = 0;

  operand_fetch_ctrl dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_use_rs1(iss_use_rs1), .iss_use_rs2(iss_use_rs2), .iss_wr_rd(iss_wr_rd),
    .iss_tag(iss_tag),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_rs1_val(op_rs1_val), .op_rs2_val(op_rs2_val),
    .op_rd(op_rd), .op_wr_rd(op_wr_rd), .op_tag(op_tag),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_addr_p0(rf_addr_p0), .rf_addr_p1(rf_addr_p1),
    .rf_re_p0(rf_re_p0), .rf_re_p1(rf_re_p1),
    .rf_dout_p0(rf_dout_p0), .rf_dout_p1(rf_dout_p1),
    .rf_addr_p2(rf_addr_p2), .rf_we_p2(rf_we_p2), .rf_din_p2(rf_din_p2),
    .err_wb_unexp(err_wb_unexp)
  );

  always #5 clk = ~clk;

  // Register array model; x0 and idle ports return garbage the DUT must not use
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (rf_we_p2) mem[rf_addr_p2] <= rf_din_p2;
    rf_dout_p0 <= !rf_re_p0 ? 32'hBAD0BAD0 : (rf_addr_p0 == 5'd0) ? 32'hDEADBEEF : mem[rf_addr_p0];
    rf_dout_p1 <= !rf_re_p1 ? 32'hBAD0BAD0 : (rf_addr_p1 == 5'd0) ? 32'hDEADBEEF : mem[rf_addr_p1];
  end

  typedef struct {
    logic [31:0] v1, v2;
    logic [4:0]  rd;
    logic        wr;
    logic [3:0]  tag;
  } exp_t;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, wr;
    logic [3:0]  tag;
    logic [31:0] e1, e2;
  } vec_t;

  exp_t sb[$];
  vec_t vt[5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic expired(input string nm);
    nchk++;
    nerr++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                              input logic u2, input logic [4:0] rd, input logic wr,
                              input logic [3:0] tag, input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd; v.wr = wr;
    v.tag = tag; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic drive_iss(input vec_t v);
    iss_rs1 = v.rs1; iss_use_rs1 = v.u1;
    iss_rs2 = v.rs2; iss_use_rs2 = v.u2;
    iss_rd  = v.rd;  iss_wr_rd   = v.wr;
    iss_tag = v.tag;
  endtask

  // Waits for iss_ready, takes the accept edge, queues the expected result
  task automatic issue(input vec_t v, output bit ok);
    exp_t e;
    ok = 1'b0;
    drive_iss(v);
    iss_valid = 1'b1;
    #1;
    for (int i = 0; i < 50; i++) begin
      if (iss_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) expired("issue_ready");
    else begin
      @(posedge clk);
      #1;
      e.v1 = v.e1; e.v2 = v.e2; e.rd = v.rd; e.wr = v.wr; e.tag = v.tag;
      sb.push_back(e);
    end
    iss_valid = 1'b0;
  endtask

  // Waits for op_valid, compares against the queue head, completes the handshake
  task automatic collect(output int lat);
    exp_t e;
    lat = 0;
    op_ready = 1'b1;
    while (!op_valid && lat < 20) begin
      step();
      lat++;
    end
    if (!op_valid) expired("op_valid");
    else if (sb.size() == 0) expired("sb_empty");
    else begin
      e = sb.pop_front();
      chk("op_rs1_val", op_rs1_val, e.v1);
      chk("op_rs2_val", op_rs2_val, e.v2);
      chk("op_rd_wr_tag", {op_rd, op_wr_rd, op_tag}, {e.rd, e.wr, e.tag});
      step();
      chk("op_valid_drop", op_valid, 1'b0);
    end
  endtask

  task automatic do_wb(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1'b1; wb_rd = r; wb_data = d;
    step();
    wb_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok;
    int   lat;
    vec_t v;

    vt[0] = mk(5'd1, 1, 5'd2, 1, 5'd0, 0, 4'h3, 32'hA5A5A5A5, 32'h5A5A5A5A);
    vt[1] = mk(5'd0, 1, 5'd1, 1, 5'd0, 0, 4'h5, 32'h0,        32'hA5A5A5A5);
    vt[2] = mk(5'd2, 1, 5'd1, 0, 5'd0, 0, 4'h6, 32'h5A5A5A5A, 32'h0);
    vt[3] = mk(5'd1, 0, 5'd2, 0, 5'd0, 1, 4'hF, 32'h0,        32'h0);
    vt[4] = mk(5'd2, 1, 5'd0, 1, 5'd3, 0, 4'hA, 32'h5A5A5A5A, 32'h0);

    reset = 1'b1; iss_valid = 1'b0; op_ready = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    drive_iss(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) step();
    chk("rst_op_valid", op_valid, 1'b0);
    chk("rst_ctrl", {rf_re_p0, rf_re_p1, rf_we_p2, err_wb_unexp, iss_ready}, 5'b00001);
    chk("rst_addr", {rf_addr_p0, rf_addr_p1, rf_addr_p2, op_rd, op_wr_rd, op_tag}, 30'h0);
    chk("rst_data", {op_rs1_val, op_rs2_val, rf_din_p2}, 96'h0);
    reset = 1'b0;
    step();

    do_wb(5'd0, 32'hFFFFFFFF);
    chk("x0_no_we", rf_we_p2, 1'b0);
    step();
    chk("x0_no_err", err_wb_unexp, 1'b0);

    do_wb(5'd7, 32'h00000077);
    chk("x7_we", {rf_we_p2, rf_addr_p2, rf_din_p2}, {1'b1, 5'd7, 32'h00000077});
    chk("x7_err", err_wb_unexp, 1'b1);
    step();
    chk("x7_we_one_cycle", rf_we_p2, 1'b0);
    repeat (3) step();
    chk("err_sticky", err_wb_unexp, 1'b1);
    chk("x7_array", mem[7], 32'h00000077);

    do_wb(5'd1, 32'hA5A5A5A5);
    do_wb(5'd2, 32'h5A5A5A5A);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("err_cleared", err_wb_unexp, 1'b0);
    step();

    for (int i = 0; i < 5; i++) begin
      issue(vt[i], ok);
      if (ok) begin
        collect(lat);
        chk("latency", lat, 2);
      end
    end

    // RAW: x5 pending until its writeback commits
    issue(mk(5'd0, 0, 5'd0, 0, 5'd5, 1, 4'h7, 32'h0, 32'h0), ok);
    if (ok) collect(lat);
    v = mk(5'd5, 1, 5'd0, 0, 5'd0, 0, 4'h8, 32'h12345678, 32'h0);
    drive_iss(v);
    iss_valid = 1'b1;
    #1;
    chk("raw_stall0", iss_ready, 1'b0);
    step();
    chk("raw_stall1", iss_ready, 1'b0);
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h12345678;
    step();
    wb_valid = 1'b0;
    chk("raw_stall_commit", {iss_ready, rf_we_p2}, 2'b01);
    step();
    chk("raw_release", iss_ready, 1'b1);
    chk("raw_no_err", err_wb_unexp, 1'b0);
    issue(v, ok);
    if (ok) collect(lat);

    // Back-pressure: operands frozen, no new reads, no issue
    op_ready = 1'b0;
    issue(mk(5'd1, 1, 5'd2, 1, 5'd0, 0, 4'h9, 32'hA5A5A5A5, 32'h5A5A5A5A), ok);
    lat = 0;
    while (!op_valid && lat < 10) begin
      step();
      lat++;
    end
    for (int k = 0; k < 4; k++) begin
      chk("bp_hold", {op_valid, iss_ready, rf_re_p0, rf_re_p1, op_rs1_val, op_rs2_val, op_tag},
          {1'b1, 1'b0, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, 4'h9});
      step();
    end
    collect(lat);

    // Reset while holding operands for an instruction that marked x10 busy
    op_ready = 1'b0;
    issue(mk(5'd1, 1, 5'd0, 0, 5'd10, 1, 4'hC, 32'hA5A5A5A5, 32'h0), ok);
    lat = 0;
    while (!op_valid && lat < 10) begin
      step();
      lat++;
    end
    chk("pre_rst_hold", op_valid, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    chk("rst_hold_valid", {op_valid, rf_we_p2}, 2'b00);
    drive_iss(mk(5'd10, 1, 5'd0, 0, 5'd10, 1, 4'h1, 32'h0, 32'h0));
    #1;
    chk("rst_sb_empty", iss_ready, 1'b1);
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
